if_prefetch_stage: RTL and testbench
====================================

# if_prefetch_stage

Parametrised instruction-fetch stage for the ARM pipeline. It replaces the fixed single-instruction IF stage with a PC generator, a variable-latency instruction-memory handshake and a DEPTH-entry prefetch queue. It sits between instruction memory and the IF/ID register. It absorbs ID-side stalls (freeze) and flushes on branch redirects from EXE.

## Interface
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction word width
- DEPTH, 4, prefetch queue entries; power of two, 2..16
- PC_STEP, 4, byte increment between sequential fetches
- RESET_PC, 0, first fetch address after reset

Ports; one clock; reset is asynchronous and active-high:
- clk  in  1  pipeline clock (CLOCK_50 domain)
- rst  in  1  asynchronous, active-high reset
- branch_taken  in  1  redirect request from EXE
- branch_addr  in  ADDR_W  redirect target
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address
- imem_ack  in  1  data valid for the current request; may be combinational from imem_req
- imem_rdata  in  INSTR_W  fetched word, valid with imem_ack
- out_valid  out  1  queue head valid
- out_ready  in  1  IF/ID accepts head (~freeze)
- out_pc  out  ADDR_W  head address + PC_STEP (ARM PC+4 convention)
- out_instr  out  INSTR_W  head instruction
- perf_fetch_cnt  out  32  accepted fetches (see Configuration)
- perf_flush_cnt  out  32  branch flushes (see Configuration)

## Operation
- fetch_pc register starts at RESET_PC and advances by PC_STEP (modulo 2^ADDR_W) on each accepted ack.
- At most one request is outstanding at a time.
- A new request is issued only when the queue count is below DEPTH.
- FSM states:
  - IDLE: assert imem_req if there is space; go to WAIT on the same edge unless ack arrives.
  - WAIT: hold req and addr stable until imem_ack.
  - DISCARD: a request was outstanding at a flush; hold the old req/addr until ack, drop that data, then return to IDLE.
- Transitions from WAIT:
  - ack without branch: push {fetch_pc+PC_STEP, rdata}, increment fetch_pc, go to IDLE (or stay in WAIT if a back-to-back request issues).
  - branch without ack: go to DISCARD.
  - branch with ack on the same edge: drop the data, go to IDLE.
- Branch has priority over push, pop and ack. On a branch:
  - queue cleared; out_valid is 0 on the next cycle.
  - fetch_pc set to branch_addr.
  - the pop in that cycle is ignored.
- Queue:
  - pop on out_valid && out_ready; push and pop on the same edge are both honoured.
  - the head is registered; an empty queue gives out_valid=0 and leaves out_instr holding its last value.
- Full queue: imem_req stays low until a pop occurs. Overflow is impossible by construction.
- Reset mid-transaction: state returns to IDLE, any in-flight ack is ignored, and the queue is cleared.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0, both counters 0.
  - FSM in IDLE, queue count 0.
- imem_req rises in the first cycle after rst deasserts.
- Ack latency:
  - with combinational ack, out_valid rises one edge after the ack edge, and sustained throughput is 1 instruction/cycle.
  - with an N-cycle ack, latency is N+1 cycles.
- Redirect:
  - imem_addr=branch_addr one cycle after branch_taken when no request is outstanding.
  - if a request is outstanding, imem_addr=branch_addr in the cycle after the discarded ack.
- imem_addr changes only in IDLE or on an ack edge. It never changes while in WAIT or DISCARD.

## Configuration
- IF_PERF_COUNT_EN defined:
  - perf_fetch_cnt increments on every pushed instruction.
  - perf_flush_cnt increments on every branch_taken cycle.
  - both are 32-bit, wrap at 2^32, and reset to 0.
- IF_PERF_COUNT_EN undefined: both ports are constant 0 and no counter flops are inferred.

## Structure
- Package arm_if_pkg holds:
  - the FSM state enum (IDLE, WAIT, DISCARD);
  - default constants for RESET_PC and PC_STEP;
  - the queue-entry struct {pc, instr}.
- Sub-module if_instr_fifo: a DEPTH×(ADDR_W+INSTR_W) synchronous FIFO with push, pop, clear, count and registered head. Clear has priority over push.
- The PC/FSM logic lives in the top level.

## Test plan
- Reset release, combinational ack, out_ready=1 → imem_addr sequence 0,4,8,12; out_pc 4,8,12,16 on consecutive cycles; out_valid continuous from the second cycle.
- out_ready=0 with DEPTH=4 → exactly 4 pushes, then imem_req=0. Raise out_ready → one pop per cycle; req re-asserts the cycle after the first pop.
- 3-cycle ack latency; branch_taken to 0x100 in the first WAIT cycle → old ack dropped, queue empty, next imem_addr=0x100, first out_pc=0x104.
- branch_taken coincident with ack and a pop → data dropped, out_valid=0 next cycle, perf_flush_cnt=1.
- rst asserted in WAIT with ack pending → all outputs return to reset values immediately; the late ack is ignored after release.
- IF_PERF_COUNT_EN undefined → counters read 0 after 100 fetches; defined → perf_fetch_cnt=100.

Source files
------------

// File: rtl/arm_if_pkg.sv
// Shared types and defaults for the ARM instruction-fetch prefetch stage.
package arm_if_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_STEP  = 32'h0000_0004;

    // Queue entry layout for the default 32-bit address/instruction build.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } q_entry_t;

endpackage

// File: rtl/if_instr_fifo.sv
// Prefetch queue: circular buffer with a registered head entry; clear beats push.
module if_instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       push_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_valid,
    output logic [WIDTH-1:0]       head_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = '0;
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      cnt_stay;
    logic [AW:0]      cnt_next;
    logic [WIDTH-1:0] head_next;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (count != CNT_ZERO);
    assign do_push = push && ((count != CNT_FULL) || do_pop);

    // Next pointer/count and the entry that becomes head after this edge.
    always_comb begin
        rd_next   = rd_ptr;
        cnt_stay  = count;
        cnt_next  = count;
        head_next = head_data;
        if (do_pop) begin
            rd_next  = rd_ptr + PTR_ONE;
            cnt_stay = count - CNT_ONE;
        end else begin
            rd_next  = rd_ptr;
            cnt_stay = count;
        end
        if (do_push) begin
            cnt_next = cnt_stay + CNT_ONE;
        end else begin
            cnt_next = cnt_stay;
        end
        // An entry pushed into an otherwise-empty queue bypasses the array.
        if (cnt_stay == CNT_ZERO) begin
            head_next = push_data;
        end else begin
            head_next = mem[rd_next];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and registered head; head data holds when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else if (clear) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
        end else begin
            rd_ptr     <= rd_next;
            count      <= cnt_next;
            head_valid <= (cnt_next != CNT_ZERO);
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (cnt_next != CNT_ZERO) begin
                head_data <= head_next;
            end
        end
    end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: PC generator, single-outstanding imem handshake, prefetch queue.
// Optional performance counters are built when IF_PERF_COUNT_EN is defined.
module if_prefetch_stage
    import arm_if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(DEFAULT_PC_STEP),
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_flush_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    fetch_state_e      state_r;
    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] pc_inc;
    logic [CW-1:0]     q_count;
    logic [CW-1:0]     cnt_after;
    logic              push;
    logic              pop;
    logic              space;

    assign pc_inc = fetch_pc_r + PC_STEP;
    assign push   = (state_r == WAIT) && imem_ack && !branch_taken;
    assign pop    = out_valid && out_ready && !branch_taken;

    // Queue occupancy after this edge decides whether a new request may issue.
    always_comb begin
        cnt_after = q_count;
        if (push && !pop) begin
            cnt_after = q_count + CNT_ONE;
        end else if (pop && !push) begin
            cnt_after = q_count - CNT_ONE;
        end else begin
            cnt_after = q_count;
        end
    end

    assign space = (cnt_after < CNT_FULL);

    if_instr_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(ADDR_W + INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (branch_taken),
        .push_data ({pc_inc, imem_rdata}),
        .count     (q_count),
        .head_valid(out_valid),
        .head_data ({out_pc, out_instr})
    );

    // Fetch FSM; imem_req/imem_addr only move in IDLE or on an ack edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
        end else begin
            case (state_r)
                IDLE: begin
                    if (branch_taken) begin
                        fetch_pc_r <= branch_addr;
                        imem_addr  <= branch_addr;
                        imem_req   <= 1'b1;
                        state_r    <= WAIT;
                    end else if (space) begin
                        imem_addr <= fetch_pc_r;
                        imem_req  <= 1'b1;
                        state_r   <= WAIT;
                    end else begin
                        imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (branch_taken && imem_ack) begin
                        fetch_pc_r <= branch_addr;
                        imem_addr  <= branch_addr;
                        imem_req   <= 1'b0;
                        state_r    <= IDLE;
                    end else if (branch_taken) begin
                        fetch_pc_r <= branch_addr;
                        state_r    <= DISCARD;
                    end else if (imem_ack) begin
                        fetch_pc_r <= pc_inc;
                        imem_addr  <= pc_inc;
                        imem_req   <= space;
                        state_r    <= space ? WAIT : IDLE;
                    end
                end
                DISCARD: begin
                    // The stale response is dropped; the redirect target goes out next.
                    if (imem_ack) begin
                        if (branch_taken) begin
                            fetch_pc_r <= branch_addr;
                            imem_addr  <= branch_addr;
                        end else begin
                            imem_addr <= fetch_pc_r;
                        end
                        imem_req <= 1'b0;
                        state_r  <= IDLE;
                    end else if (branch_taken) begin
                        fetch_pc_r <= branch_addr;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

`ifdef IF_PERF_COUNT_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (branch_taken) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_fetch_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with a combinational or fixed-latency imem model.
module tb_if_prefetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;

    logic        comb_mode = 1'b1;
    logic        force_ack = 1'b0;
    logic        ack_r;
    int          lat = 3;
    int          wcnt;
    int          checks = 0;
    int          errors = 0;

`ifdef IF_PERF_COUNT_EN
    localparam logic PERF_EN = 1'b1;
`else
    localparam logic PERF_EN = 1'b0;
`endif

    if_prefetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .branch_taken  (branch_taken),
        .branch_addr   (branch_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hE3A0_0000;
    endfunction

    assign imem_rdata = word_at(imem_addr);
    assign imem_ack   = comb_mode ? imem_req : (ack_r | force_ack);

    // Fixed-latency memory: ack pulses lat cycles after the request is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r <= 1'b0;
            wcnt  <= 0;
        end else if (ack_r) begin
            ack_r <= 1'b0;
            wcnt  <= 0;
        end else if (imem_req && !comb_mode) begin
            if (wcnt == lat - 1) ack_r <= 1'b1;
            else wcnt <= wcnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic start(input logic comb, input int l, input logic rdy);
        rst = 1'b1;
        comb_mode = comb;
        lat = l;
        out_ready = rdy;
        branch_taken = 1'b0;
        force_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_fcnt", perf_fetch_cnt, 32'd0);
        chk("rst_flcnt", perf_flush_cnt, 32'd0);

        // Combinational ack streaming at one instruction per cycle
        start(1'b1, 1, 1'b1);
        tick();
        chk("s2_req1", {31'd0, imem_req}, 32'd1);
        chk("s2_addr0", imem_addr, 32'd0);
        chk("s2_valid0", {31'd0, out_valid}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("s2_valid", {31'd0, out_valid}, 32'd1);
            chk("s2_pc", out_pc, 32'(4 * k));
            chk("s2_instr", out_instr, word_at(32'(4 * (k - 1))));
            if (k < 4) chk("s2_addr", imem_addr, 32'(4 * k));
        end

        // Stalled consumer fills the queue, then drains
        start(1'b1, 1, 1'b0);
        repeat (5) tick();
        chk("s3_req_full", {31'd0, imem_req}, 32'd0);
        chk("s3_valid", {31'd0, out_valid}, 32'd1);
        chk("s3_head", out_pc, 32'd4);
        tick();
        chk("s3_req_hold", {31'd0, imem_req}, 32'd0);
        chk("s3_addr_hold", imem_addr, 32'd16);
        out_ready = 1'b1;
        tick();
        chk("s3_req_re", {31'd0, imem_req}, 32'd1);
        chk("s3_addr16", imem_addr, 32'd16);
        chk("s3_pop1", out_pc, 32'd8);
        tick();
        chk("s3_pop2", out_pc, 32'd12);
        chk("s3_addr20", imem_addr, 32'd20);
        tick();
        chk("s3_pop3", out_pc, 32'd16);
        tick();
        chk("s3_pop4", out_pc, 32'd20);
        chk("s3_instr4", out_instr, word_at(32'd16));

        // 3-cycle memory, redirect while a request is outstanding
        start(1'b0, 3, 1'b1);
        tick();
        chk("s4_req", {31'd0, imem_req}, 32'd1);
        branch_taken = 1'b1;
        branch_addr = 32'h100;
        tick();
        branch_taken = 1'b0;
        chk("s4_req_held", {31'd0, imem_req}, 32'd1);
        chk("s4_addr_held", imem_addr, 32'd0);
        chk("s4_flushed", {31'd0, out_valid}, 32'd0);
        tick();
        tick();
        tick();
        chk("s4_addr_redir", imem_addr, 32'h100);
        chk("s4_no_push", {31'd0, out_valid}, 32'd0);
        wait_valid("s4_wait", 20);
        chk("s4_pc", out_pc, 32'h104);
        chk("s4_instr", out_instr, word_at(32'h100));

        // Redirect coincident with ack and pop
        start(1'b1, 1, 1'b1);
        tick();
        tick();
        chk("s5_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("s5_pre_pc", out_pc, 32'd4);
        branch_taken = 1'b1;
        branch_addr = 32'h200;
        tick();
        branch_taken = 1'b0;
        chk("s5_valid0", {31'd0, out_valid}, 32'd0);
        chk("s5_req0", {31'd0, imem_req}, 32'd0);
        chk("s5_addr", imem_addr, 32'h200);
        chk("s5_flcnt", perf_flush_cnt, PERF_EN ? 32'd1 : 32'd0);
        chk("s5_fcnt", perf_fetch_cnt, PERF_EN ? 32'd1 : 32'd0);
        tick();
        chk("s5_req1", {31'd0, imem_req}, 32'd1);
        tick();
        chk("s5_valid1", {31'd0, out_valid}, 32'd1);
        chk("s5_pc", out_pc, 32'h204);

        // Reset while waiting; a stray ack right after release is ignored
        start(1'b0, 5, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("s6_req", {31'd0, imem_req}, 32'd0);
        chk("s6_addr", imem_addr, 32'd0);
        chk("s6_valid", {31'd0, out_valid}, 32'd0);
        chk("s6_pc", out_pc, 32'd0);
        tick();
        rst = 1'b0;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        chk("s6_req_rel", {31'd0, imem_req}, 32'd1);
        chk("s6_addr_rel", imem_addr, 32'd0);
        chk("s6_valid_rel", {31'd0, out_valid}, 32'd0);
        wait_valid("s6_wait", 20);
        chk("s6_first_pc", out_pc, 32'd4);

        // 100 fetches with combinational ack
        start(1'b1, 1, 1'b1);
        repeat (101) tick();
        chk("s7_pc", out_pc, 32'd400);
        chk("s7_addr", imem_addr, 32'd400);
        chk("s7_fcnt", perf_fetch_cnt, PERF_EN ? 32'd100 : 32'd0);
        chk("s7_flcnt", perf_flush_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
